// File: rtl/ram_fifo_ctrl_pkg.sv
// Shared sizing and FSM encoding for the RAM-backed FIFO controller.
package ram_fifo_ctrl_pkg;

    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int DEPTH = 2 ** AW;

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Producer/consumer handshake and occupancy bundle of the RAM FIFO.
interface ram_fifo_ctrl_if #(
    parameter int DW = ram_fifo_ctrl_pkg::DW,
    parameter int AW = ram_fifo_ctrl_pkg::AW
);

    logic          wr_valid;
    logic [DW-1:0] wr_data;
    logic          wr_ready;
    logic          rd_req;
    logic          rd_ack;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic          full;
    logic          empty;
    logic [AW:0]   count;

    modport master (
        output wr_valid, wr_data, rd_req,
        input  wr_ready, rd_ack, rd_valid, rd_data,
        input  full, empty, count
    );

    modport slave (
        input  wr_valid, wr_data, rd_req,
        output wr_ready, rd_ack, rd_valid, rd_data,
        output full, empty, count
    );

endinterface

// File: rtl/ram_16x8.sv
// Single-port synchronous RAM, registered read, no reset on contents.
module ram_16x8 #(
    parameter int DW = ram_fifo_ctrl_pkg::DW,
    parameter int AW = ram_fifo_ctrl_pkg::AW
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [2**AW];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= din;
        end
        dout <= mem[addr];
    end

endmodule

// File: rtl/ram_fifo_16x8.sv
// FIFO controller joined to its 16x8 RAM macro.
module ram_fifo_16x8 (
    input  logic           clk,
    input  logic           rst_n,
    ram_fifo_ctrl_if.slave bus
);

    import ram_fifo_ctrl_pkg::*;

    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_fifo_ctrl u_ctrl (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    ram_16x8 u_ram (
        .clk  (clk),
        .we   (ram_wr_en),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

endmodule

// File: rtl/ram_fifo_ctrl.sv
// 16-entry FIFO controller arbitrating one access per cycle
// to an external single-port RAM with one-cycle read latency.
module ram_fifo_ctrl #(
    parameter int DW = ram_fifo_ctrl_pkg::DW,
    parameter int AW = ram_fifo_ctrl_pkg::AW
) (
    input  logic          clk,
    input  logic          rst_n,
    ram_fifo_ctrl_if.slave bus,
    output logic          ram_wr_en,
    output logic [AW-1:0] ram_addr,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    import ram_fifo_ctrl_pkg::*;

    localparam logic [AW:0] FULL_CNT = (AW+1)'(2 ** AW);

    state_t        state;
    state_t        state_nxt;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   cnt;
    logic          prio_rd;
    logic          full;
    logic          empty;
    logic          wr_elig;
    logic          rd_elig;
    logic          gnt_wr;
    logic          gnt_rd;
    logic          rd_valid_q;
    logic [DW-1:0] rd_data_q;

    assign full      = (cnt == FULL_CNT);
    assign empty     = (cnt == '0);
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = cnt;

    assign bus.rd_valid = rd_valid_q;
    assign bus.rd_data  = rd_data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:    if (gnt_rd) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // prio_rd set means the last contended cycle went to write
    always_comb begin
        wr_elig = (state == IDLE) && bus.wr_valid && !full;
        rd_elig = (state == IDLE) && bus.rd_req && !empty;
        gnt_wr  = 1'b0;
        gnt_rd  = 1'b0;
        unique case (1'b1)
            wr_elig && rd_elig: begin
                gnt_rd = prio_rd;
                gnt_wr = !prio_rd;
            end
            wr_elig && !rd_elig: gnt_wr = 1'b1;
            rd_elig && !wr_elig: gnt_rd = 1'b1;
            default: ;
        endcase
        bus.wr_ready = gnt_wr;
        bus.rd_ack   = gnt_rd;
        ram_wr_en    = gnt_wr;
        ram_addr     = gnt_wr ? wr_ptr : rd_ptr;
        ram_din      = bus.wr_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            cnt     <= '0;
            prio_rd <= 1'b0;
        end else begin
            if (gnt_wr) begin
                wr_ptr <= wr_ptr + 1'b1;
                cnt    <= cnt + 1'b1;
            end
            if (gnt_rd) begin
                rd_ptr <= rd_ptr + 1'b1;
                cnt    <= cnt - 1'b1;
            end
            if (wr_elig && rd_elig) begin
                prio_rd <= gnt_wr;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= (state == RD_WAIT);
            if (state == RD_WAIT) begin
                rd_data_q <= ram_dout;
            end
        end
    end

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl: vector table, queue scoreboard, corner sequences.
module tb_ram_fifo_ctrl;

    import ram_fifo_ctrl_pkg::*;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ram_wr_en;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;

    ram_fifo_ctrl_if bus ();

    ram_fifo_ctrl dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .ram_wr_en (ram_wr_en),
        .ram_addr  (ram_addr),
        .ram_din   (ram_din),
        .ram_dout  (ram_dout)
    );

    ram_16x8 u_ram (
        .clk  (clk),
        .we   (ram_wr_en),
        .addr (ram_addr),
        .din  (ram_din),
        .dout (ram_dout)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(int n);
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b0;
        repeat (n) step();
    endtask

    // Scoreboard: reference FIFO queue and grant model, sampled on negedge
    logic [7:0] m_q[$];
    bit         m_wait;
    bit         m_rv;
    bit         m_prio_rd;
    logic [7:0] m_wait_d;
    logic [7:0] m_rv_d;
    logic [3:0] m_wp;
    logic [3:0] m_rp;
    int         rv_seen = 0;

    always @(negedge clk) begin
        bit mf, me, we, re, gw, gr;
        if (!rst_n) begin
            m_q.delete();
            m_wait    = 0;
            m_rv      = 0;
            m_prio_rd = 0;
            m_wp      = '0;
            m_rp      = '0;
            chk("rst count", int'(bus.count), 0);
            chk("rst empty", int'(bus.empty), 1);
            chk("rst rd_valid", int'(bus.rd_valid), 0);
            chk("rst rd_data", int'(bus.rd_data), 0);
        end else begin
            mf = (m_q.size() == 16);
            me = (m_q.size() == 0);
            we = !m_wait && bus.wr_valid && !mf;
            re = !m_wait && bus.rd_req && !me;
            gw = we && (!re || !m_prio_rd);
            gr = re && (!we || m_prio_rd);
            chk("sb count", int'(bus.count), m_q.size());
            chk("sb full", int'(bus.full), int'(mf));
            chk("sb empty", int'(bus.empty), int'(me));
            chk("sb wr_ready", int'(bus.wr_ready), int'(gw));
            chk("sb rd_ack", int'(bus.rd_ack), int'(gr));
            chk("sb ram_wr_en", int'(ram_wr_en), int'(gw));
            chk("sb ram_addr", int'(ram_addr),
                int'(gw ? m_wp : m_rp));
            chk("sb rd_valid", int'(bus.rd_valid), int'(m_rv));
            if (m_rv) begin
                chk("sb rd_data", int'(bus.rd_data), int'(m_rv_d));
            end
            if (bus.rd_valid) rv_seen++;
            m_rv   = m_wait;
            m_rv_d = m_wait_d;
            m_wait = gr;
            if (we && re) m_prio_rd = gw;
            if (gr) begin
                m_wait_d = m_q.pop_front();
                m_rp     = m_rp + 1'b1;
            end
            if (gw) begin
                m_q.push_back(bus.wr_data);
                m_wp = m_wp + 1'b1;
            end
        end
    end

    typedef struct {
        logic       wv;
        logic [7:0] wd;
        logic       rr;
        logic       ewr;
        logic       eack;
        int         ecnt;
        logic       erv;
        logic [7:0] erd;
        logic       eempty;
    } vec_t;

    vec_t  tbl[7];
    string pat_exp;
    byte   pat[6];
    int    rv0;

    initial begin
        tbl[0] = '{1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[1] = '{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 1, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 2, 1'b0, 8'h00, 1'b0};
        tbl[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1, 1'b1, 8'hAA, 1'b0};
        tbl[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b0, 8'h00, 1'b1};
        tbl[6] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 0, 1'b1, 8'h55, 1'b1};

        bus.wr_valid = 1'b0;
        bus.wr_data  = '0;
        bus.rd_req   = 1'b0;
        rst_n        = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // two pushes then two pops, cycle by cycle
        for (int i = 0; i < 7; i++) begin
            bus.wr_valid = tbl[i].wv;
            bus.wr_data  = tbl[i].wd;
            bus.rd_req   = tbl[i].rr;
            @(negedge clk);
            chk($sformatf("vec%0d wr_ready", i),
                int'(bus.wr_ready), int'(tbl[i].ewr));
            chk($sformatf("vec%0d rd_ack", i),
                int'(bus.rd_ack), int'(tbl[i].eack));
            chk($sformatf("vec%0d count", i),
                int'(bus.count), tbl[i].ecnt);
            chk($sformatf("vec%0d rd_valid", i),
                int'(bus.rd_valid), int'(tbl[i].erv));
            chk($sformatf("vec%0d empty", i),
                int'(bus.empty), int'(tbl[i].eempty));
            if (tbl[i].erv) begin
                chk($sformatf("vec%0d rd_data", i),
                    int'(bus.rd_data), int'(tbl[i].erd));
            end
            @(posedge clk);
            #1;
        end
        idle(2);

        // fill to 16, then refused 17th push
        for (int i = 0; i < 16; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(i);
            step();
        end
        bus.wr_data = 8'h77;
        @(negedge clk);
        chk("full wr_ready", int'(bus.wr_ready), 0);
        chk("full flag", int'(bus.full), 1);
        chk("full count", int'(bus.count), 16);
        step();
        bus.wr_valid = 1'b0;
        @(negedge clk);
        chk("full hold count", int'(bus.count), 16);
        step();
        bus.rd_req = 1'b1;
        repeat (32) step();
        idle(3);
        chk("drain empty", int'(bus.empty), 1);

        // 40 alternating ops across the pointer wrap
        rv0 = rv_seen;
        for (int i = 0; i < 20; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h20 + i);
            bus.rd_req   = 1'b0;
            step();
            bus.wr_valid = 1'b0;
            bus.rd_req   = 1'b1;
            step();
            bus.rd_req = 1'b0;
            step();
        end
        idle(3);
        chk("alt rd_valid pulses", rv_seen - rv0, 20);
        chk("alt count", int'(bus.count), 0);

        // contention from fresh reset with count=4
        rst_n = 1'b0;
        idle(2);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h40 + i);
            step();
        end
        pat_exp = "WR-WR-";
        for (int k = 0; k < 6; k++) begin
            bus.wr_valid = 1'b1;
            bus.wr_data  = 8'(8'h50 + k);
            bus.rd_req   = 1'b1;
            @(negedge clk);
            pat[k] = bus.wr_ready ? "W" : (bus.rd_ack ? "R" : "-");
            chk($sformatf("arb slot%0d", k), int'(pat[k]),
                int'(pat_exp[k]));
            @(posedge clk);
            #1;
        end
        idle(3);
        chk("arb count", int'(bus.count), 4);
        bus.rd_req = 1'b1;
        repeat (8) step();
        idle(3);
        chk("arb drained", int'(bus.empty), 1);

        // pop while empty
        rv0 = rv_seen;
        bus.rd_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("empty pop rd_ack", int'(bus.rd_ack), 0);
            step();
        end
        idle(3);
        chk("empty pop pulses", rv_seen - rv0, 0);

        // reset during RD_WAIT drops the pending read
        bus.wr_valid = 1'b1;
        bus.wr_data  = 8'h99;
        step();
        bus.wr_valid = 1'b0;
        bus.rd_req   = 1'b1;
        step();
        bus.rd_req = 1'b0;
        rst_n      = 1'b0;
        rv0        = rv_seen;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort rd_valid", int'(bus.rd_valid), 0);
            chk("abort count", int'(bus.count), 0);
            step();
        end
        chk("abort pulses", rv_seen - rv0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ram_fifo_ctrl.md
RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 Parameter: DW, 8, data width.
REQ-002 Parameter: AW, 4, address width; depth is 2**AW = 16.
REQ-003 Port: clk  in  1  single clock; all state changes on posedge.
REQ-004 Port: rst_n  in  1  asynchronous active-low reset.
REQ-005 Port: wr_valid  in  1  producer has a byte to push.
REQ-006 Port: wr_data  in  DW  byte to push.
REQ-007 Port: wr_ready  out  1  push accepted this cycle (wr_valid && wr_ready).
REQ-008 Port: rd_req  in  1  consumer requests a pop.
REQ-009 Port: rd_ack  out  1  pop accepted this cycle.
REQ-010 Port: rd_valid  out  1  one-cycle pulse, rd_data holds the popped byte.
REQ-011 Port: rd_data  out  DW  popped byte, registered.
REQ-012 Port: full, empty  out  1 each  occupancy flags.
REQ-013 Port: count  out  AW+1  occupancy 0..16.
REQ-014 Port: ram_wr_en, ram_addr[AW-1:0], ram_din[DW-1:0]  out  drive ram_16x8.
REQ-015 Port: ram_dout  in  DW  from ram_16x8; valid one clock after ram_addr is presented with ram_wr_en=0.

Function
REQ-016 The block SHALL implement a 16-entry FIFO over the single-port ram_16x8, allowing at most one RAM access per cycle.
REQ-017 FSM states SHALL be IDLE and RD_WAIT; IDLE->RD_WAIT on read grant; RD_WAIT->IDLE unconditionally after one cycle.
REQ-018 In IDLE, write is eligible iff wr_valid && !full, and read is eligible iff rd_req && !empty.
REQ-019 If both are eligible, the grant SHALL go to the op not granted on the previous contended cycle; the first contention after reset goes to write.
REQ-020 On write grant: wr_ready=1, ram_wr_en=1, ram_addr=wr_ptr, ram_din=wr_data; wr_ptr+1 and count+1 at the clock edge.
REQ-021 On read grant: rd_ack=1, ram_wr_en=0, ram_addr=rd_ptr; rd_ptr+1 and count-1 at the clock edge.
REQ-022 In RD_WAIT no grants occur: wr_ready=0, rd_ack=0, ram_wr_en=0.
REQ-023 rd_data SHALL load ram_dout at the end of the RD_WAIT cycle, and rd_valid SHALL be high for exactly the following cycle, giving 2 cycles of latency from rd_ack to rd_valid.
REQ-024 Pointers SHALL wrap modulo 16 (15+1=0); count SHALL never exceed 16 or go below 0.
REQ-025 full=(count==16) and empty=(count==0), decoded from registered count.
REQ-026 A write to a full FIFO and a read from an empty FIFO SHALL be ignored with no state change.
REQ-027 When idle with no grant: ram_wr_en=0, ram_addr=rd_ptr, ram_din=wr_data.
REQ-028 wr_ready and rd_ack SHALL be combinational from registered state and the current request inputs only.

Reset
REQ-029 While rst_n=0: state=IDLE, wr_ptr=0, rd_ptr=0, count=0, rd_data=0, rd_valid=0, and contention priority = write.
REQ-030 Reset asserted during RD_WAIT SHALL abort the read: no rd_valid pulse, and the popped entry is lost.
REQ-031 RAM contents are not cleared by reset.

Structure
REQ-032 A shared package SHALL hold DW, AW, DEPTH and the FSM state enum.
REQ-033 ram_16x8 SHALL remain a separate module; ram_fifo_ctrl does not instantiate it. A wrapper ram_fifo_16x8 connects the two.

Verification
REQ-034 Reset, push 0xAA then 0x55 -> count=2; pop -> rd_valid 2 cycles after rd_ack with rd_data=0xAA; next pop -> 0x55, empty=1.
REQ-035 Push 16 bytes 0x00..0x0F -> full=1, count=16; a 17th push with wr_valid=1 -> wr_ready=0 and the FIFO is unchanged.
REQ-036 Perform 40 alternating push/pop operations of incrementing values -> both pointers wrap and the data order is preserved with no loss.
REQ-037 With count=4, hold wr_valid and rd_req high for 6 cycles -> grants alternate W,R,W,... (RD_WAIT cycles grant nothing) and count returns to 4.
REQ-038 Pop while empty -> rd_ack=0 and no rd_valid pulse; assert rst_n=0 in RD_WAIT -> no rd_valid pulse, count=0.
